dma_req_seq: RTL and testbench

DMA_REQ_SEQ -- requirements
Module: dma_req_seq

---
 rtl/dma_req_seq.sv | 150 +++++++++++++++
 tb/tb_dma_req_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_req_seq.sv
// rtl/dma_req_seq.sv - queued DMA command sequencer: FIFO of {dir,len}, launch/arm/transfer/interrupt FSM with timeout.
module dma_req_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_dir,
    input  logic [WIDTH-1:0]         cmd_len,
    input  logic                     dma_busy,
    input  logic                     dma_int,
    output logic                     start,
    output logic                     ctrl_RD_en,
    output logic                     ctrl_WR_en,
    output logic [WIDTH-1:0]         data_len,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_XFER,
        S_WAIT_INT,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [WIDTH:0]    mem [DEPTH];
    logic [AW:0]       wptr, rptr;
    logic              push, pop;
    logic              dir, dir_n;
    logic [WIDTH-1:0]  len, len_n;
    logic [WIDTH-1:0]  beat, beat_n;
    logic [15:0]       tmo_cnt, tmo_n;
    logic              tmo_err;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign pending   = wptr - rptr;
    assign cmd_ready = (pending != (AW+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {cmd_dir, cmd_len};
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        dir_n   = dir;
        len_n   = len;
        beat_n  = beat;
        tmo_n   = tmo_cnt;
        tmo_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending != '0) begin
                    pop     = 1'b1;
                    dir_n   = mem[rptr[AW-1:0]][WIDTH];
                    len_n   = mem[rptr[AW-1:0]][WIDTH-1:0];
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_n   = '0;
                state_n = S_ARM;
            end
            S_ARM: begin
                // A late handshake on the final timeout cycle still wins.
                if (dma_busy) begin
                    beat_n  = '0;
                    state_n = S_XFER;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_err = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            S_XFER: begin
                if (beat == len) begin
                    tmo_n   = '0;
                    state_n = S_WAIT_INT;
                end else begin
                    beat_n = beat + 1'b1;
                end
            end
            S_WAIT_INT: begin
                if (dma_int) begin
                    state_n = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_err = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            dir        <= 1'b0;
            len        <= '0;
            beat       <= '0;
            tmo_cnt    <= '0;
            start      <= 1'b0;
            ctrl_RD_en <= 1'b0;
            ctrl_WR_en <= 1'b0;
            data_len   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            dir        <= dir_n;
            len        <= len_n;
            beat       <= beat_n;
            tmo_cnt    <= tmo_n;
            start      <= (state_n == S_LAUNCH);
            ctrl_RD_en <= ((state_n == S_ARM) || (state_n == S_XFER)) && !dir_n;
            ctrl_WR_en <= ((state_n == S_ARM) || (state_n == S_XFER)) && dir_n;
            data_len   <= (state_n == S_IDLE) ? '0 : len_n;
            done       <= (state_n == S_DONE);
            err        <= tmo_err;
        end
    end

endmodule

// File: tb/tb_dma_req_seq.sv
// tb/tb_dma_req_seq.sv - directed self-checking bench for dma_req_seq (WIDTH=8, DEPTH=4, TMO=10).
module tb_dma_req_seq;

    logic       clk;
    logic       arst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_len;
    logic       dma_busy;
    logic       dma_int;
    logic       start;
    logic       ctrl_RD_en;
    logic       ctrl_WR_en;
    logic [7:0] data_len;
    logic       done;
    logic       err;
    logic [2:0] pending;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_start, cnt_rd, cnt_wr, cnt_done, cnt_err;

    dma_req_seq #(.WIDTH(8), .DEPTH(4), .TMO(10)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_len    (cmd_len),
        .dma_busy   (dma_busy),
        .dma_int    (dma_int),
        .start      (start),
        .ctrl_RD_en (ctrl_RD_en),
        .ctrl_WR_en (ctrl_WR_en),
        .data_len   (data_len),
        .done       (done),
        .err        (err),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr_cnt();
        cnt_start = 0; cnt_rd = 0; cnt_wr = 0; cnt_done = 0; cnt_err = 0;
    endtask

    // Advance one edge, then sample the registered outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        if (start)      cnt_start++;
        if (ctrl_RD_en) cnt_rd++;
        if (ctrl_WR_en) cnt_wr++;
        if (done)       cnt_done++;
        if (err)        cnt_err++;
        if (ctrl_RD_en && ctrl_WR_en) check("both_en", 1, 0);
    endtask

    // Called in a LAUNCH cycle of a write command that never sees dma_busy.
    task automatic launch_timeout(input logic [7:0] l, input string tag);
        check({tag, "_start"}, start, 1);
        check({tag, "_len"}, data_len, l);
        step();
        check({tag, "_arm_wr"}, ctrl_WR_en, 1);
        repeat (9) step();
        check({tag, "_last_arm_err"}, err, 0);
        step();
        check({tag, "_err"}, err, 1);
        check({tag, "_wr_drop"}, ctrl_WR_en, 0);
    endtask

    initial begin
        arst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = 8'd0;
        dma_busy = 1'b0; dma_int = 1'b0;
        #2;
        check("rst_start", start, 0);
        check("rst_en", {ctrl_RD_en, ctrl_WR_en}, 0);
        check("rst_pending", pending, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_len", data_len, 0);
        check("rst_done_err", {done, err}, 0);
        repeat (2) step();
        arst_n = 1'b1;

        // Read, len=3, busy two cycles after start, interrupt five cycles after enable drops.
        clr_cnt();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 8'd3;
        step();
        cmd_valid = 1'b0;
        check("t1_pending", pending, 1);
        step();
        check("t1_start", start, 1);
        check("t1_len", data_len, 3);
        step();
        check("t1_arm_rd", ctrl_RD_en, 1);
        check("t1_pop", pending, 0);
        step();
        dma_busy = 1'b1;
        step();
        dma_busy = 1'b0;
        check("t1_xfer_rd", ctrl_RD_en, 1);
        repeat (3) step();
        check("t1_xfer_last_rd", ctrl_RD_en, 1);
        step();
        check("t1_wait_rd", ctrl_RD_en, 0);
        check("t1_wait_len", data_len, 3);
        repeat (4) step();
        dma_int = 1'b1;
        step();
        dma_int = 1'b0;
        check("t1_done", done, 1);
        step();
        check("t1_done_one", done, 0);
        check("t1_idle_len", data_len, 0);
        repeat (3) step();
        check("t1_cnt_start", cnt_start, 1);
        check("t1_cnt_rd", cnt_rd, 6);
        check("t1_cnt_wr", cnt_wr, 0);
        check("t1_cnt_done", cnt_done, 1);
        check("t1_cnt_err", cnt_err, 0);

        // Write, len=0: ARM plus a single XFER cycle.
        clr_cnt();
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 8'd0;
        step();
        cmd_valid = 1'b0;
        step();
        check("t2_start", start, 1);
        check("t2_len", data_len, 0);
        step();
        check("t2_arm_wr", ctrl_WR_en, 1);
        dma_busy = 1'b1;
        step();
        dma_busy = 1'b0;
        check("t2_xfer_wr", ctrl_WR_en, 1);
        step();
        check("t2_wait_wr", ctrl_WR_en, 0);
        dma_int = 1'b1;
        step();
        dma_int = 1'b0;
        check("t2_done", done, 1);
        step();
        check("t2_cnt_wr", cnt_wr, 2);
        check("t2_cnt_rd", cnt_rd, 0);
        check("t2_cnt_done", cnt_done, 1);

        // Fill FIFO while the FSM waits in ARM, then let every command time out.
        clr_cnt();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 8'd1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("t3_arm_rd", ctrl_RD_en, 1);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 8'(10 + i);
            step();
            check($sformatf("t3_pending_%0d", i), pending, (i < 4) ? i + 1 : 4);
            check($sformatf("t3_ready_%0d", i), cmd_ready, (i < 3) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        repeat (4) step();
        check("t3_pre_tmo_err", err, 0);
        check("t3_pre_tmo_rd", ctrl_RD_en, 1);
        step();
        check("t3_err", err, 1);
        check("t3_err_rd", ctrl_RD_en, 0);
        check("t3_err_len", data_len, 0);
        check("t3_err_pending", pending, 4);
        for (int i = 0; i < 4; i++) begin
            step();
            launch_timeout(8'(10 + i), $sformatf("t3_q%0d", i));
        end
        step();
        check("t3_drained_start", start, 0);
        check("t3_drained_pending", pending, 0);
        check("t3_cnt_err", cnt_err, 5);
        check("t3_cnt_done", cnt_done, 0);

        // Interrupt arriving on the timeout cycle of WAIT_INT wins; stray int in IDLE/LAUNCH ignored.
        clr_cnt();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 8'd0;
        step();
        cmd_valid = 1'b0;
        dma_int = 1'b1;
        step();
        step();
        dma_int = 1'b0;
        check("t4_arm_rd", ctrl_RD_en, 1);
        check("t4_stray_int", done, 0);
        dma_busy = 1'b1;
        step();
        dma_busy = 1'b0;
        step();
        check("t4_wait_rd", ctrl_RD_en, 0);
        repeat (9) step();
        check("t4_pre_err", err, 0);
        dma_int = 1'b1;
        step();
        dma_int = 1'b0;
        check("t4_done", done, 1);
        check("t4_no_err", err, 0);
        step();
        check("t4_after_err", err, 0);
        check("t4_cnt_done", cnt_done, 1);

        // Reset during XFER with a second command queued.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 8'd5;
        step();
        cmd_len = 8'd7;
        step();
        cmd_valid = 1'b0;
        check("t5_queued", pending, 1);
        step();
        dma_busy = 1'b1;
        step();
        dma_busy = 1'b0;
        step();
        check("t5_xfer_wr", ctrl_WR_en, 1);
        arst_n = 1'b0;
        #1;
        check("t5_rst_en", {ctrl_RD_en, ctrl_WR_en}, 0);
        check("t5_rst_start_done_err", {start, done, err}, 0);
        check("t5_rst_pending", pending, 0);
        check("t5_rst_ready", cmd_ready, 1);
        check("t5_rst_len", data_len, 0);
        repeat (2) step();
        arst_n = 1'b1;
        clr_cnt();
        repeat (8) step();
        check("t5_no_done", cnt_done, 0);
        check("t5_no_start", cnt_start, 0);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 8'd2;
        step();
        cmd_valid = 1'b0;
        step();
        check("t5_resume_start", start, 1);
        check("t5_resume_len", data_len, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
